// File: rtl/predictor_pkg.sv
// Shared types for the branch-predictor update path.
// Entries are sized for the widest supported PC; narrower PCs are zero-extended.
package predictor_pkg;

    localparam int PC_MAX = 64;

    typedef struct packed {
        logic [PC_MAX-1:0] pc;
        logic [PC_MAX-1:0] target;
        logic              taken;
    } upd_entry_t;

endpackage

// File: rtl/predictor_update_arbiter_if.sv
// Resolve-port / predictor-update bundle for predictor_update_arbiter.
interface predictor_update_arbiter_if #(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               flush;
    logic               a_valid;
    logic [PC_BITS-1:0] a_pc;
    logic [PC_BITS-1:0] a_target;
    logic               a_taken;
    logic               b_valid;
    logic [PC_BITS-1:0] b_pc;
    logic [PC_BITS-1:0] b_target;
    logic               b_taken;
    logic               in_ready;
    logic               upd_valid;
    logic [PC_BITS-1:0] upd_pc;
    logic [PC_BITS-1:0] upd_target;
    logic               upd_taken;
    logic [CW-1:0]      count;
    logic               drop_err;

    modport master (
        output flush, a_valid, a_pc, a_target, a_taken,
        output b_valid, b_pc, b_target, b_taken,
        input  in_ready, upd_valid, upd_pc, upd_target, upd_taken,
        input  count, drop_err
    );

    modport slave (
        input  flush, a_valid, a_pc, a_target, a_taken,
        input  b_valid, b_pc, b_target, b_taken,
        output in_ready, upd_valid, upd_pc, upd_target, upd_taken,
        output count, drop_err
    );

endinterface

// File: rtl/upd_fifo_2w1r.sv
// Circular update queue: two write ports (tail, tail+1), one read port.
// Head is consumed every cycle the queue is non-empty.
module upd_fifo_2w1r
    import predictor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_we0,
    input  upd_entry_t                 i_wd0,
    input  logic                       i_we1,
    input  upd_entry_t                 i_wd1,
    output upd_entry_t                 o_rd,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    upd_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_deq;
    logic [PW-1:0] w_tail1;
    logic [PW-1:0] w_tail_nx;
    logic [CW-1:0] w_nwr;

    assign w_deq     = (r_count != '0);
    assign w_tail1   = r_tail + PW'(1);
    assign w_nwr     = CW'(i_we0) + CW'(i_we1);
    assign w_tail_nx = i_we1 ? r_tail + PW'(2) :
                       i_we0 ? w_tail1 : r_tail;

    // Payload needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[r_tail]  <= i_wd0;
        if (i_we1) r_mem[w_tail1] <= i_wd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq) r_head <= r_head + PW'(1);
            r_tail  <= w_tail_nx;
            r_count <= r_count + w_nwr - CW'(w_deq);
        end
    end

    assign o_rd    = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/predictor_update_arbiter.sv
// Serialises up to two resolved branches per cycle into one predictor update
// per cycle, coalescing same-PC pairs and flagging drops when full.
module predictor_update_arbiter
    import predictor_pkg::*;
#(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    predictor_update_arbiter_if.slave       bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    upd_entry_t    w_ent_a;
    upd_entry_t    w_ent_b;
    upd_entry_t    w_wd0;
    upd_entry_t    w_head;
    logic [CW-1:0] w_count;
    logic          w_in_ready;
    logic          w_any;
    logic          w_same_pc;
    logic          w_pair;
    logic          w_acc;
    logic          w_we0;
    logic          w_we1;
    logic          r_drop_err;
    logic          w_unused;

    always_comb begin
        w_ent_a        = '0;
        w_ent_a.pc     = PC_MAX'(bus.a_pc);
        w_ent_a.target = PC_MAX'(bus.a_target);
        w_ent_a.taken  = bus.a_taken;
        w_ent_b        = '0;
        w_ent_b.pc     = PC_MAX'(bus.b_pc);
        w_ent_b.target = PC_MAX'(bus.b_target);
        w_ent_b.taken  = bus.b_taken;
    end

    // Registered occupancy only: a same-cycle dequeue never raises ready.
    assign w_in_ready = (w_count <= CW'(DEPTH - 2));

    assign w_any     = bus.a_valid | bus.b_valid;
    assign w_same_pc = (bus.a_pc == bus.b_pc);
    assign w_pair    = bus.a_valid & bus.b_valid & ~w_same_pc;
    assign w_acc     = w_in_ready & ~bus.flush;

    // Older A goes first; B alone or B winning a coalesce lands in the tail.
    assign w_we0 = w_acc & w_any;
    assign w_we1 = w_acc & w_pair;
    assign w_wd0 = (bus.a_valid & (~bus.b_valid | w_pair)) ? w_ent_a : w_ent_b;

    upd_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_we0   (w_we0),
        .i_wd0   (w_wd0),
        .i_we1   (w_we1),
        .i_wd1   (w_ent_b),
        .o_rd    (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_err <= 1'b0;
        else if (~bus.flush & ~w_in_ready & w_any)
            r_drop_err <= 1'b1;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.upd_valid  = (w_count != '0);
    assign bus.upd_pc     = w_head.pc[PC_BITS-1:0];
    assign bus.upd_target = w_head.target[PC_BITS-1:0];
    assign bus.upd_taken  = w_head.taken;
    assign bus.count      = w_count;
    assign bus.drop_err   = r_drop_err;

    assign w_unused = ^{w_head.pc, w_head.target};

endmodule

// File: tb/tb_predictor_update_arbiter.sv
// Directed vector bench for predictor_update_arbiter (PC_BITS=32, DEPTH=4).
module tb_predictor_update_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    predictor_update_arbiter_if #(.PC_BITS(32), .DEPTH(4)) bus ();

    predictor_update_arbiter #(
        .PC_BITS (32),
        .DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        av;
        logic [31:0] apc;
        logic [31:0] atg;
        logic        at;
        logic        bv;
        logic [31:0] bpc;
        logic [31:0] btg;
        logic        bt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] etg;
        logic        et;
        logic [2:0]  ecnt;
        logic        erdy;
        logic        edrop;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic drive(input logic fl, input logic av,
                         input logic [31:0] apc, input logic [31:0] atg,
                         input logic at, input logic bv,
                         input logic [31:0] bpc, input logic [31:0] btg,
                         input logic bt);
        bus.flush    = fl;
        bus.a_valid  = av;
        bus.a_pc     = apc;
        bus.a_target = atg;
        bus.a_taken  = at;
        bus.b_valid  = bv;
        bus.b_pc     = bpc;
        bus.b_target = btg;
        bus.b_taken  = bt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        //          fl av apc       atg       at bv bpc      btg       bt ev epc      etg       et cnt rdy drp
        vt[0]  = '{0, 1, 32'h100, 32'h200, 1, 0, 32'h0,  32'h0,    0, 1, 32'h100, 32'h200, 1, 1, 1, 0};
        vt[1]  = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 0};
        vt[2]  = '{0, 1, 32'h10,  32'h1010,0, 1, 32'h20, 32'h1020, 1, 1, 32'h10,  32'h1010,0, 2, 1, 0};
        vt[3]  = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 1, 32'h20,  32'h1020,1, 1, 1, 0};
        vt[4]  = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 0};
        vt[5]  = '{0, 1, 32'h40,  32'h1040,0, 1, 32'h40, 32'h2040, 1, 1, 32'h40,  32'h2040,1, 1, 1, 0};
        vt[6]  = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 0};
        vt[7]  = '{0, 1, 32'h50,  32'h1050,1, 1, 32'h54, 32'h1054, 0, 1, 32'h50,  32'h1050,1, 2, 1, 0};
        vt[8]  = '{0, 1, 32'h58,  32'h1058,1, 1, 32'h5C, 32'h105C, 1, 1, 32'h54,  32'h1054,0, 3, 0, 0};
        vt[9]  = '{0, 1, 32'h60,  32'h1060,1, 1, 32'h64, 32'h1064, 1, 1, 32'h58,  32'h1058,1, 2, 1, 1};
        vt[10] = '{0, 1, 32'h68,  32'h1068,0, 0, 32'h0,  32'h0,    0, 1, 32'h5C,  32'h105C,1, 2, 1, 1};
        vt[11] = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 1, 32'h68,  32'h1068,0, 1, 1, 1};
        vt[12] = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 1};
        vt[13] = '{0, 0, 32'h0,   32'h0,   0, 1, 32'h70, 32'h1070, 0, 1, 32'h70,  32'h1070,0, 1, 1, 1};
        vt[14] = '{0, 1, 32'h80,  32'h1080,1, 1, 32'h84, 32'h1084, 0, 1, 32'h80,  32'h1080,1, 2, 1, 1};
        vt[15] = '{0, 1, 32'h88,  32'h1088,1, 1, 32'h8C, 32'h108C, 1, 1, 32'h84,  32'h1084,0, 3, 0, 1};
        vt[16] = '{1, 1, 32'h90,  32'h1090,1, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 1};
        vt[17] = '{0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   32'h0,   0, 0, 1, 1};

        rst = 1'b1;
        idle();
        #1;
        chk("rst_valid", 64'(bus.upd_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_drop", 64'(bus.drop_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].fl, vt[i].av, vt[i].apc, vt[i].atg, vt[i].at,
                  vt[i].bv, vt[i].bpc, vt[i].btg, vt[i].bt);
            tick();
            idle();
            chk($sformatf("v%0d_valid", i), 64'(bus.upd_valid), 64'(vt[i].ev));
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vt[i].ecnt));
            chk($sformatf("v%0d_ready", i), 64'(bus.in_ready), 64'(vt[i].erdy));
            chk($sformatf("v%0d_drop", i), 64'(bus.drop_err), 64'(vt[i].edrop));
            if (vt[i].ev) begin
                chk($sformatf("v%0d_pc", i), 64'(bus.upd_pc), 64'(vt[i].epc));
                chk($sformatf("v%0d_tgt", i), 64'(bus.upd_target),
                    64'(vt[i].etg));
                chk($sformatf("v%0d_taken", i), 64'(bus.upd_taken),
                    64'(vt[i].et));
            end
        end

        // Asynchronous reset between edges with two entries queued.
        drive(0, 1, 32'hA0, 32'h10A0, 1, 1, 32'hA4, 32'h10A4, 0);
        tick();
        idle();
        chk("ar_pre_count", 64'(bus.count), 64'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(bus.upd_valid), 64'd0);
        chk("ar_count", 64'(bus.count), 64'd0);
        chk("ar_ready", 64'(bus.in_ready), 64'd1);
        chk("ar_drop", 64'(bus.drop_err), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_post_valid", 64'(bus.upd_valid), 64'd0);
        chk("ar_post_count", 64'(bus.count), 64'd0);

        drive(0, 1, 32'hB0, 32'h10B0, 0, 0, 0, 0, 0);
        tick();
        idle();
        chk("ar_new_valid", 64'(bus.upd_valid), 64'd1);
        chk("ar_new_pc", 64'(bus.upd_pc), 64'hB0);
        tick();
        chk("ar_new_drain", 64'(bus.upd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
